// File: rtl/dsp38_fir_seq_pkg.sv
// Shared types and constants for the DSP38 FIR sequencer.
// Widths follow the DSP38 A/B/Z pins; FEEDBACK codes select clear vs accumulate.
package dsp38_fir_seq_pkg;

  localparam int DATA_W = 18;
  localparam int COEF_W = 20;
  localparam int Z_W    = 38;
  localparam int TAP_W  = 5;   // holds 0..16

  localparam logic [2:0] FB_ACC = 3'b000;
  localparam logic [2:0] FB_CLR = 3'b001;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    OUTPUT
  } state_e;

endpackage

// File: rtl/dsp38_fir_delay_line.sv
// Circular sample history for the FIR: write pointer, flush, and a read port
// returning the sample k steps older than the most recent one.
module dsp38_fir_delay_line
  import dsp38_fir_seq_pkg::*;
#(
  parameter int NUM_TAPS = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic [TAP_W-1:0]  rd_tap,
  output logic [DATA_W-1:0] rd_data
);

  localparam int PTR_W = $clog2(NUM_TAPS);
  localparam int IDX_W = PTR_W + 2;

  logic [DATA_W-1:0] taps_q [NUM_TAPS];
  logic [PTR_W-1:0]  wp_q;
  logic [IDX_W-1:0]  idx_sum;

  // NOTE: history must read as zero after reset and flush, so this small
  // register file is reset explicitly rather than treated as an uninitialised RAM.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wp_q <= '0;
      for (int i = 0; i < NUM_TAPS; i++) taps_q[i] <= '0;
    end else if (flush) begin
      wp_q <= '0;
      for (int i = 0; i < NUM_TAPS; i++) taps_q[i] <= '0;
    end else if (wr_en) begin
      taps_q[wp_q] <= wr_data;
      wp_q         <= (wp_q == PTR_W'(NUM_TAPS - 1)) ? '0 : wp_q + 1'b1;
    end
  end

  // NOTE: idx_sum is assigned on every path before use, so no latch is inferred.
  always_comb begin
    idx_sum = {2'b00, wp_q} + IDX_W'(NUM_TAPS - 1) - IDX_W'(rd_tap);
    if (idx_sum >= IDX_W'(NUM_TAPS)) idx_sum = idx_sum - IDX_W'(NUM_TAPS);
  end

  assign rd_data = taps_q[idx_sum[PTR_W-1:0]];

endmodule

// File: rtl/dsp38_fir_sequencer.sv
// Initiator-side MAC sequencer for one DSP38: streams taps, waits out the Z
// pipeline and returns Z. Optional FLUSH port enabled by DSP38_FIR_FLUSH_EN.
module dsp38_fir_sequencer
  import dsp38_fir_seq_pkg::*;
#(
  parameter int NUM_TAPS    = 8,
  parameter int Z_LATENCY   = 3,
  parameter int OUT_SHIFT   = 0,
  parameter int SIGNED_DATA = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
`ifdef DSP38_FIR_FLUSH_EN
  input  logic              FLUSH,
`endif
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] S_DATA,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [Z_W-1:0]    M_DATA,
  input  logic              COEF_WE,
  input  logic [3:0]        COEF_ADDR,
  input  logic [COEF_W-1:0] COEF_WDATA,
  output logic              COEF_READY,
  output logic [COEF_W-1:0] DSP_A,
  output logic [DATA_W-1:0] DSP_B,
  output logic [2:0]        DSP_FEEDBACK,
  output logic              DSP_LOAD_ACC,
  output logic              DSP_SUBTRACT,
  output logic              DSP_ROUND,
  output logic              DSP_SATURATE,
  output logic [5:0]        DSP_ACC_FIR,
  output logic [5:0]        DSP_SHIFT_RIGHT,
  output logic              DSP_UNSIGNED_A,
  output logic              DSP_UNSIGNED_B,
  input  logic [Z_W-1:0]    DSP_Z
);

  localparam int PTR_W = $clog2(NUM_TAPS);

  state_e              state_q;
  logic [TAP_W-1:0]    tap_cnt_q;
  logic [TAP_W-1:0]    drain_cnt_q;
  logic [COEF_W-1:0]   coef_q [NUM_TAPS];
  logic                s_ready_q;
  logic                m_valid_q;
  logic [Z_W-1:0]      m_data_q;
  logic [COEF_W-1:0]   dsp_a_q;
  logic [DATA_W-1:0]   dsp_b_q;
  logic [2:0]          dsp_fb_q;
  logic                dsp_load_q;

  logic                flush_now;
  logic                accept;
  logic                coef_wr;
  logic [COEF_W-1:0]   h0_eff;
  logic [DATA_W-1:0]   line_rd;

  assign DSP_SUBTRACT    = 1'b0;
  assign DSP_ROUND       = 1'b0;
  assign DSP_SATURATE    = 1'b0;
  assign DSP_ACC_FIR     = 6'd0;
  assign DSP_SHIFT_RIGHT = 6'(OUT_SHIFT);
  assign DSP_UNSIGNED_A  = (SIGNED_DATA == 0);
  assign DSP_UNSIGNED_B  = (SIGNED_DATA == 0);

  assign DSP_A        = dsp_a_q;
  assign DSP_B        = dsp_b_q;
  assign DSP_FEEDBACK = dsp_fb_q;
  assign DSP_LOAD_ACC = dsp_load_q;
  assign M_VALID      = m_valid_q;
  assign M_DATA       = m_data_q;

`ifdef DSP38_FIR_FLUSH_EN
  logic flush_pend_q;

  // A flush requested while busy is remembered and run on the next IDLE cycle.
  assign flush_now = (state_q == IDLE) && (FLUSH || flush_pend_q);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                       flush_pend_q <= 1'b0;
    else if (flush_now)                 flush_pend_q <= 1'b0;
    else if (FLUSH && state_q != IDLE)  flush_pend_q <= 1'b1;
  end
`else
  assign flush_now = 1'b0;
`endif

  assign S_READY    = s_ready_q && !flush_now;
  assign COEF_READY = s_ready_q;
  assign accept     = S_VALID && S_READY;
  assign coef_wr    = COEF_WE && COEF_READY && ({1'b0, COEF_ADDR} < TAP_W'(NUM_TAPS));

  // Same-cycle write to h[0] must be seen by the tap issued on the accept edge.
  assign h0_eff = (coef_wr && COEF_ADDR == 4'd0) ? COEF_WDATA : coef_q[0];

  dsp38_fir_delay_line #(
    .NUM_TAPS (NUM_TAPS)
  ) u_delay_line (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .wr_en   (accept),
    .wr_data (S_DATA),
    .flush   (flush_now),
    .rd_tap  (tap_cnt_q),
    .rd_data (line_rd)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      tap_cnt_q   <= '0;
      drain_cnt_q <= '0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      dsp_fb_q    <= FB_ACC;
      dsp_load_q  <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) coef_q[i] <= '0;
    end else begin
      if (coef_wr) coef_q[COEF_ADDR[PTR_W-1:0]] <= COEF_WDATA;

      case (state_q)
        IDLE: begin
          s_ready_q <= 1'b1;
          if (accept) begin
            state_q    <= ISSUE;
            s_ready_q  <= 1'b0;
            dsp_a_q    <= h0_eff;
            dsp_b_q    <= S_DATA;
            dsp_fb_q   <= FB_CLR;
            dsp_load_q <= 1'b1;
            tap_cnt_q  <= TAP_W'(1);
          end
        end

        ISSUE: begin
          if (tap_cnt_q == TAP_W'(NUM_TAPS)) begin
            state_q     <= DRAIN;
            dsp_a_q     <= '0;
            dsp_b_q     <= '0;
            dsp_fb_q    <= FB_ACC;
            dsp_load_q  <= 1'b0;
            drain_cnt_q <= TAP_W'(1);
          end else begin
            dsp_a_q    <= coef_q[tap_cnt_q[PTR_W-1:0]];
            dsp_b_q    <= line_rd;
            dsp_fb_q   <= FB_ACC;
            dsp_load_q <= 1'b1;
            tap_cnt_q  <= tap_cnt_q + 1'b1;
          end
        end

        DRAIN: begin
          if (drain_cnt_q == TAP_W'(Z_LATENCY)) begin
            state_q   <= OUTPUT;
            m_data_q  <= DSP_Z;
            m_valid_q <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end

        OUTPUT: begin
          if (M_READY) begin
            state_q   <= IDLE;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp38_fir_sequencer.sv
// Directed bench for dsp38_fir_sequencer with a behavioural signed DSP38 MAC
// (input regs, accumulator, output reg). FLUSH steps run under DSP38_FIR_FLUSH_EN.
module tb_dsp38_fir_sequencer;
  import dsp38_fir_seq_pkg::*;

  localparam int N  = 4;
  localparam int ZL = 3;

  logic              CLK = 1'b0;
  logic              RESET_N = 1'b0;
  logic              FLUSH = 1'b0;
  logic              S_VALID = 1'b0;
  logic              S_READY;
  logic [DATA_W-1:0] S_DATA = '0;
  logic              M_VALID;
  logic              M_READY = 1'b1;
  logic [Z_W-1:0]    M_DATA;
  logic              COEF_WE = 1'b0;
  logic [3:0]        COEF_ADDR = '0;
  logic [COEF_W-1:0] COEF_WDATA = '0;
  logic              COEF_READY;
  logic [COEF_W-1:0] DSP_A;
  logic [DATA_W-1:0] DSP_B;
  logic [2:0]        DSP_FEEDBACK;
  logic              DSP_LOAD_ACC, DSP_SUBTRACT, DSP_ROUND, DSP_SATURATE;
  logic [5:0]        DSP_ACC_FIR, DSP_SHIFT_RIGHT;
  logic              DSP_UNSIGNED_A, DSP_UNSIGNED_B;
  logic [Z_W-1:0]    DSP_Z;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 CLK = ~CLK;

  dsp38_fir_sequencer #(
    .NUM_TAPS(N), .Z_LATENCY(ZL), .OUT_SHIFT(0), .SIGNED_DATA(1)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
`ifdef DSP38_FIR_FLUSH_EN
    .FLUSH(FLUSH),
`endif
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
    .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_WDATA(COEF_WDATA),
    .COEF_READY(COEF_READY),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_FEEDBACK(DSP_FEEDBACK),
    .DSP_LOAD_ACC(DSP_LOAD_ACC), .DSP_SUBTRACT(DSP_SUBTRACT),
    .DSP_ROUND(DSP_ROUND), .DSP_SATURATE(DSP_SATURATE),
    .DSP_ACC_FIR(DSP_ACC_FIR), .DSP_SHIFT_RIGHT(DSP_SHIFT_RIGHT),
    .DSP_UNSIGNED_A(DSP_UNSIGNED_A), .DSP_UNSIGNED_B(DSP_UNSIGNED_B),
    .DSP_Z(DSP_Z)
  );

  // Behavioural DSP38 in MAC mode, sharing the sequencer reset.
  logic signed [Z_W-1:0] m_a, m_b, m_acc, m_z;
  logic [2:0]            m_fb;
  logic                  m_ld;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_a <= '0; m_b <= '0; m_fb <= '0; m_ld <= 1'b0; m_acc <= '0; m_z <= '0;
    end else begin
      m_a  <= Z_W'($signed(DSP_A));
      m_b  <= Z_W'($signed(DSP_B));
      m_fb <= DSP_FEEDBACK;
      m_ld <= DSP_LOAD_ACC;
      if (m_ld) m_acc <= ((m_fb == 3'b001) ? '0 : m_acc) + m_a * m_b;
      m_z <= m_acc >>> DSP_SHIFT_RIGHT;
    end
  end
  assign DSP_Z = m_z;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_sready(input string tag);
    int n = 0;
    while (!S_READY && n < 40) begin
      @(negedge CLK); #1;
      n++;
    end
    check(tag, 64'(S_READY), 64'd1);
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [COEF_W-1:0] val);
    wait_sready("coef_wait_ready");
    COEF_WE = 1'b1; COEF_ADDR = addr; COEF_WDATA = val;
    @(negedge CLK);
    COEF_WE = 1'b0;
  endtask

  task automatic write_h(input int h0, input int h1, input int h2, input int h3);
    write_coef(4'd0, COEF_W'(h0));
    write_coef(4'd1, COEF_W'(h1));
    write_coef(4'd2, COEF_W'(h2));
    write_coef(4'd3, COEF_W'(h3));
  endtask

  // Accepts x, checks the first two tap cycles, returns one cycle into ISSUE.
  task automatic send_sample(input logic [DATA_W-1:0] x);
    wait_sready("sample_wait_ready");
    S_VALID = 1'b1; S_DATA = x;
    @(negedge CLK);
    S_VALID = 1'b0; S_DATA = '0;
    check("tap0_b", 64'(DSP_B), 64'(x));
    check("tap0_fb_clr", 64'(DSP_FEEDBACK), 64'd1);
    @(negedge CLK);
    check("tap1_fb_acc", 64'(DSP_FEEDBACK), 64'd0);
    check("tap1_load", 64'(DSP_LOAD_ACC), 64'd1);
  endtask

  task automatic expect_result(input string tag, input logic [Z_W-1:0] exp);
    int n = 1;
    while (!M_VALID && n < 40) begin
      @(negedge CLK);
      n++;
    end
    lat = n;
    check({tag, "_valid"}, 64'(M_VALID), 64'd1);
    check(tag, 64'(M_DATA), 64'(exp));
  endtask

  task automatic run(input logic [DATA_W-1:0] x, input logic [Z_W-1:0] exp, input string tag);
    send_sample(x);
    expect_result(tag, exp);
    @(negedge CLK);
  endtask

  task automatic pulse_reset();
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    int seen;

    // Reset state
    #2;
    check("rst_s_ready", 64'(S_READY), 64'd0);
    check("rst_m_valid", 64'(M_VALID), 64'd0);
    check("rst_m_data", 64'(M_DATA), 64'd0);
    check("rst_dsp_a", 64'(DSP_A), 64'd0);
    check("rst_dsp_b", 64'(DSP_B), 64'd0);
    check("rst_dsp_fb", 64'(DSP_FEEDBACK), 64'd0);
    check("rst_dsp_load", 64'(DSP_LOAD_ACC), 64'd0);
    check("const_unsigned_a", 64'(DSP_UNSIGNED_A), 64'd0);
    check("const_shift", 64'(DSP_SHIFT_RIGHT), 64'd0);
    check("const_misc", 64'({DSP_SUBTRACT, DSP_ROUND, DSP_SATURATE, DSP_ACC_FIR}), 64'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK); #1;
    check("idle_coef_ready", 64'(COEF_READY), 64'd1);

    // 1: impulse response; out-of-range address write must not alias onto h0
    write_h(1, 2, 3, 4);
    write_coef(4'd4, COEF_W'(100));
    run(18'd1, 38'd1, "t1_y0");
    run(18'd0, 38'd2, "t1_y1");
    run(18'd0, 38'd3, "t1_y2");
    run(18'd0, 38'd4, "t1_y3");
    run(18'd0, 38'd0, "t1_y4");

    // 2: h0 = -1 written in the same cycle as the sample accept
    write_coef(4'd1, '0);
    write_coef(4'd2, '0);
    write_coef(4'd3, '0);
    wait_sready("t2_wait");
    COEF_WE = 1'b1; COEF_ADDR = 4'd0; COEF_WDATA = 20'hFFFFF;
    S_VALID = 1'b1; S_DATA = 18'd100;
    @(negedge CLK);
    COEF_WE = 1'b0; S_VALID = 1'b0; S_DATA = '0;
    check("t2_tap0_a", 64'(DSP_A), 64'h0FFFFF);
    @(negedge CLK);
    expect_result("t2_neg", 38'h3FFFFFFF9C);
    check("t2_latency", 64'(lat), 64'd7);
    @(negedge CLK);

    // 3: back-pressure on the result stream
    M_READY = 1'b0;
    send_sample(18'd5);
    expect_result("t3_first", 38'h3FFFFFFFFB);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        COEF_WE = 1'b1; COEF_ADDR = 4'd0; COEF_WDATA = 20'd7;
      end else begin
        COEF_WE = 1'b0;
      end
      @(negedge CLK); #1;
      check("t3_hold_data", 64'(M_DATA), 64'h3FFFFFFFFB);
      check("t3_hold_sready", 64'(S_READY), 64'd0);
    end
    COEF_WE = 1'b0;
    check("t3_coef_ready_low", 64'(COEF_READY), 64'd0);
    M_READY = 1'b1;
    @(negedge CLK); #1;
    check("t3_mvalid_drop", 64'(M_VALID), 64'd0);
    check("t3_sready_rise", 64'(S_READY), 64'd1);
    run(18'd2, 38'h3FFFFFFFFE, "t3_coef_dropped");

    // 4: reset during tap 2 aborts the result
    write_h(1, 2, 3, 4);
    send_sample(18'd9);
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("t4_rst_mvalid", 64'(M_VALID), 64'd0);
    check("t4_rst_load", 64'(DSP_LOAD_ACC), 64'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (M_VALID) seen++;
    end
    check("t4_no_mvalid", 64'(seen), 64'd0);
    write_h(1, 2, 3, 4);
    run(18'd1, 38'd1, "t4_y0");
    run(18'd0, 38'd2, "t4_y1");
    run(18'd0, 38'd3, "t4_y2");
    run(18'd0, 38'd4, "t4_y3");

    // 5: running sum across the ring wrap
    pulse_reset();
    write_h(1, 1, 1, 1);
    run(18'd5, 38'd5,  "t5_y0");
    run(18'd5, 38'd10, "t5_y1");
    run(18'd5, 38'd15, "t5_y2");
    run(18'd5, 38'd20, "t5_y3");
    run(18'd5, 38'd20, "t5_y4");
    run(18'd5, 38'd20, "t5_y5");

`ifdef DSP38_FIR_FLUSH_EN
    // 6: immediate flush beats a coincident sample; flush in OUTPUT is deferred
    pulse_reset();
    write_h(1, 2, 3, 4);
    run(18'd7, 38'd7,  "t6_y0");
    run(18'd7, 38'd21, "t6_y1");
    run(18'd7, 38'd42, "t6_y2");
    wait_sready("t6_wait");
    FLUSH = 1'b1; S_VALID = 1'b1; S_DATA = 18'd99;
    #1;
    check("t6_flush_sready", 64'(S_READY), 64'd0);
    @(negedge CLK);
    FLUSH = 1'b0; S_VALID = 1'b0; S_DATA = '0;
    #1;
    check("t6_flush_no_accept", 64'(DSP_LOAD_ACC), 64'd0);
    run(18'd1, 38'd1, "t6_after_flush");
    M_READY = 1'b0;
    send_sample(18'd3);
    expect_result("t6_before_defer", 38'd5);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    M_READY = 1'b1;
    @(negedge CLK); #1;
    check("t6_defer_sready", 64'(S_READY), 64'd0);
    run(18'd1, 38'd1, "t6_after_defer");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
